// File: rtl/rsp_s1_prep_compaction.sv
// rtl/rsp_s1_prep_compaction.sv - packs kept lanes of masked stage-1 prep words densely into full output words
// A 2*NUM-unit accumulator absorbs each compacted beat; full words are emitted, and the final remainder goes out in FLUSH.
module rsp_s1_prep_compaction #(
    parameter int READ_RAM_WIDTH = 128,
    parameter int NUM            = 8,
    parameter int DATA_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_switch,
    input  logic [READ_RAM_WIDTH-1:0] i_x0,
    input  logic [NUM-1:0]            i_keep,
    input  logic                      i_x0_valid,
    input  logic                      i_x0_last,
    output logic                      o_x0_ready,
    output logic [READ_RAM_WIDTH-1:0] o_y0,
    output logic [$clog2(NUM):0]      o_y0_cnt,
    output logic                      o_y0_valid,
    output logic                      o_y0_last,
    input  logic                      i_y0_ready
);

    localparam int RW  = READ_RAM_WIDTH;
    localparam int DW  = DATA_WIDTH;
    localparam int CW  = $clog2(NUM) + 1;
    localparam int FW  = $clog2(NUM);
    localparam int NFW = FW + 2;
    localparam logic [NFW-1:0] NUM_NF = NFW'(NUM);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t            state, state_n;
    logic [2*RW-1:0]   acc, acc_n;
    logic [FW-1:0]     fill, fill_n;
    logic [NUM-1:0]    ukeep;
    logic [RW-1:0]     packed_units;
    logic [CW-1:0]     beat_cnt;
    logic [2*RW-1:0]   merged;
    logic [NFW-1:0]    new_fill;
    logic              slot_free;
    logic              accept;
    logic              load;
    logic [RW-1:0]     y_n;
    logic [CW-1:0]     cnt_n;
    logic              last_n;

    assign slot_free  = !o_y0_valid | i_y0_ready;
    assign o_x0_ready = !rst & (state == RUN) & slot_free;
    assign accept     = i_x0_valid & o_x0_ready;

    // In complex mode one keep bit covers the I and Q units of a lane, so packing works on units only.
    always_comb begin
        ukeep        = '0;
        packed_units = '0;
        beat_cnt     = '0;
        for (int u = 0; u < NUM; u++) begin
            ukeep[u] = i_switch ? i_keep[u] : i_keep[u/2];
        end
        for (int u = 0; u < NUM; u++) begin
            if (ukeep[u]) begin
                packed_units[int'(beat_cnt)*DW +: DW] = i_x0[u*DW +: DW];
                beat_cnt = beat_cnt + CW'(1);
            end
        end
    end

    // Accumulator units at and above fill are always zero, so OR-ing is a safe append.
    assign merged   = acc | ({{RW{1'b0}}, packed_units} << (int'(fill) * DW));
    assign new_fill = NFW'(fill) + NFW'(beat_cnt);

    always_comb begin
        state_n = state;
        acc_n   = acc;
        fill_n  = fill;
        load    = 1'b0;
        y_n     = o_y0;
        cnt_n   = o_y0_cnt;
        last_n  = o_y0_last;
        if (state == RUN) begin
            if (accept) begin
                if (!i_x0_last) begin
                    if (new_fill >= NUM_NF) begin
                        load   = 1'b1;
                        y_n    = merged[RW-1:0];
                        cnt_n  = CW'(NUM);
                        last_n = 1'b0;
                        acc_n  = merged >> RW;
                        fill_n = FW'(new_fill - NUM_NF);
                    end else begin
                        acc_n  = merged;
                        fill_n = FW'(new_fill);
                    end
                end else if (new_fill <= NUM_NF) begin
                    load   = 1'b1;
                    y_n    = merged[RW-1:0];
                    cnt_n  = CW'(new_fill);
                    last_n = 1'b1;
                    acc_n  = '0;
                    fill_n = '0;
                end else begin
                    load    = 1'b1;
                    y_n     = merged[RW-1:0];
                    cnt_n   = CW'(NUM);
                    last_n  = 1'b0;
                    acc_n   = merged >> RW;
                    fill_n  = FW'(new_fill - NUM_NF);
                    state_n = FLUSH;
                end
            end
        end else begin
            if (slot_free) begin
                load    = 1'b1;
                y_n     = acc[RW-1:0];
                cnt_n   = CW'(fill);
                last_n  = 1'b1;
                acc_n   = '0;
                fill_n  = '0;
                state_n = RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            acc   <= '0;
            fill  <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            fill  <= fill_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_y0       <= '0;
            o_y0_cnt   <= '0;
            o_y0_valid <= 1'b0;
            o_y0_last  <= 1'b0;
        end else if (load) begin
            o_y0       <= y_n;
            o_y0_cnt   <= cnt_n;
            o_y0_valid <= 1'b1;
            o_y0_last  <= last_n;
        end else if (i_y0_ready) begin
            o_y0_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rsp_s1_prep_compaction.sv
// tb/tb_rsp_s1_prep_compaction.sv - directed self-checking bench for rsp_s1_prep_compaction
module tb_rsp_s1_prep_compaction;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_switch;
    logic [127:0] i_x0;
    logic [7:0]   i_keep;
    logic         i_x0_valid;
    logic         i_x0_last;
    logic         o_x0_ready;
    logic [127:0] o_y0;
    logic [3:0]   o_y0_cnt;
    logic         o_y0_valid;
    logic         o_y0_last;
    logic         i_y0_ready;

    int tests_run = 0;
    int tests_failed = 0;

    logic [127:0] q_y[$];
    logic [3:0]   q_cnt[$];
    logic         q_last[$];

    rsp_s1_prep_compaction #(.READ_RAM_WIDTH(128), .NUM(8), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .i_switch(i_switch), .i_x0(i_x0), .i_keep(i_keep),
        .i_x0_valid(i_x0_valid), .i_x0_last(i_x0_last), .o_x0_ready(o_x0_ready),
        .o_y0(o_y0), .o_y0_cnt(o_y0_cnt), .o_y0_valid(o_y0_valid), .o_y0_last(o_y0_last),
        .i_y0_ready(i_y0_ready)
    );

    always #5 clk = ~clk;

    // Handshakes complete at the following rising edge; inputs only change just after rising edges.
    always @(negedge clk) begin
        if (!rst && o_y0_valid && i_y0_ready) begin
            q_y.push_back(o_y0);
            q_cnt.push_back(o_y0_cnt);
            q_last.push_back(o_y0_last);
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic sw, input logic [127:0] x, input logic [7:0] keep, input logic last);
        bit taken = 0;
        i_switch   = sw;
        i_x0       = x;
        i_keep     = keep;
        i_x0_last  = last;
        i_x0_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (o_x0_ready) begin
                taken = 1;
                break;
            end
        end
        if (!taken) check("send_timeout", 128'd0, 128'd1);
        @(posedge clk);
        #1;
        i_x0_valid = 1'b0;
        i_x0_last  = 1'b0;
    endtask

    task automatic expect_word(input string tag, input int idx, input logic [127:0] y,
                               input logic [3:0] cnt, input logic last);
        if (idx < q_y.size()) begin
            check({tag, "_y"}, q_y[idx], y);
            check({tag, "_cnt"}, 128'(q_cnt[idx]), 128'(cnt));
            check({tag, "_last"}, 128'(q_last[idx]), 128'(last));
        end else begin
            check({tag, "_missing"}, 128'(q_y.size()), 128'(idx + 1));
        end
    endtask

    task automatic drain_and_clear();
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_y.delete();
        q_cnt.delete();
        q_last.delete();
    endtask

    logic [127:0] d[4];
    logic [127:0] lanes_k1;
    logic [127:0] a_word, b_word;

    initial begin
        rst = 1'b1; i_switch = 1'b1; i_x0 = '0; i_keep = '0;
        i_x0_valid = 1'b0; i_x0_last = 1'b0; i_y0_ready = 1'b1;
        d[0] = 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff;
        d[1] = 128'hdead_beef_0123_4567_89ab_cdef_fedc_ba98;
        d[2] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        d[3] = 128'hf0f0_0f0f_a5a5_5a5a_c3c3_3c3c_9696_6969;
        lanes_k1 = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
        a_word = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
        b_word = {32'hB3B3_0003, 32'hB2B2_0002, 32'hB1B1_0001, 32'hB0B0_0000};

        @(negedge clk);
        check("rst_ready", 128'(o_x0_ready), 128'd0);
        check("rst_valid", 128'(o_y0_valid), 128'd0);
        check("rst_y", o_y0, 128'd0);
        check("rst_cnt", 128'(o_y0_cnt), 128'd0);
        check("rst_last", 128'(o_y0_last), 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: full real words pass straight through
        send(1'b1, d[0], 8'hFF, 1'b0);
        check("t1_latency_valid", 128'(o_y0_valid), 128'd1);
        check("t1_latency_y", o_y0, d[0]);
        for (int i = 1; i < 4; i++) send(1'b1, d[i], 8'hFF, i == 3);
        drain_and_clear();
        check("t1_words", 128'(q_y.size()), 128'd4);
        for (int i = 0; i < 4; i++) expect_word($sformatf("t1_w%0d", i), i, d[i], 4'd8, i == 3);
        clear_q();

        // 2: two half words merge into one
        send(1'b1, lanes_k1, 8'h0F, 1'b0);
        send(1'b1, lanes_k1, 8'hF0, 1'b1);
        drain_and_clear();
        check("t2_words", 128'(q_y.size()), 128'd1);
        expect_word("t2_w0", 0, lanes_k1, 4'd8, 1'b1);
        clear_q();

        // 3: complex lanes overflow into FLUSH
        send(1'b0, a_word, 8'h05, 1'b0);
        send(1'b0, b_word, 8'h0E, 1'b1);
        drain_and_clear();
        check("t3_words", 128'(q_y.size()), 128'd2);
        expect_word("t3_w0", 0, {32'hB2B2_0002, 32'hB1B1_0001, 32'hA2A2_0002, 32'hA0A0_0000}, 4'd8, 1'b0);
        expect_word("t3_w1", 1, {96'd0, 32'hB3B3_0003}, 4'd2, 1'b1);
        clear_q();

        // 4: all-rejected frame still closes with an empty last word
        for (int i = 0; i < 3; i++) send(1'b1, d[i], 8'h00, i == 2);
        drain_and_clear();
        check("t4_words", 128'(q_y.size()), 128'd1);
        expect_word("t4_w0", 0, 128'd0, 4'd0, 1'b1);
        clear_q();

        // 5: downstream stall
        i_y0_ready = 1'b0;
        send(1'b1, d[1], 8'hFF, 1'b0);
        i_switch = 1'b1; i_x0 = d[2]; i_keep = 8'hFF; i_x0_last = 1'b1; i_x0_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("t5_ready_c%0d", c), 128'(o_x0_ready), 128'd0);
            check($sformatf("t5_hold_c%0d", c), o_y0, d[1]);
        end
        @(posedge clk); #1;
        i_y0_ready = 1'b1;
        send(1'b1, d[2], 8'hFF, 1'b1);
        drain_and_clear();
        check("t5_words", 128'(q_y.size()), 128'd2);
        expect_word("t5_w0", 0, d[1], 4'd8, 1'b0);
        expect_word("t5_w1", 1, d[2], 4'd8, 1'b1);
        clear_q();

        // 6: reset while parked in FLUSH
        send(1'b1, lanes_k1, 8'h0F, 1'b0);
        i_y0_ready = 1'b0;
        send(1'b1, lanes_k1, 8'hFF, 1'b1);
        @(negedge clk);
        check("t6_flush_ready", 128'(o_x0_ready), 128'd0);
        check("t6_flush_last", 128'(o_y0_last), 128'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_valid", 128'(o_y0_valid), 128'd0);
        check("t6_rst_y", o_y0, 128'd0);
        check("t6_rst_cnt", 128'(o_y0_cnt), 128'd0);
        check("t6_rst_last", 128'(o_y0_last), 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        i_y0_ready = 1'b1;
        clear_q();
        send(1'b1, lanes_k1, 8'h03, 1'b1);
        drain_and_clear();
        check("t6_words", 128'(q_y.size()), 128'd1);
        expect_word("t6_w0", 0, {96'd0, 16'd2, 16'd1}, 4'd2, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
